// File: rtl/muldiv_capture.sv
// Result capture FIFO behind a mul/div stage; optional divide-by-zero tagging with macro DIVZERO_CHECK_EN.
// Latency: 1 cycle from an accepted push to out_valid, with first-word fall-through and no same-cycle bypass.
// Backpressure: in_ready is decoded from registered count only; when full, a pop in the same cycle does not free a slot.
module muldiv_capture #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_b,
  input  logic [7:0]                 in_prod,
  input  logic [7:0]                 in_quot,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_prod,
  output logic [7:0]                 out_quot,
  output logic                       out_dz,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 dz_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    prod_mem [DEPTH];
  logic [7:0]    quot_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  logic [7:0]    quot_st;

  // Handshake decode: in_ready comes from count (and reset), never from out_ready.
  assign in_ready  = rst_n & (cnt != CW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = cnt;
  assign out_prod  = prod_mem[rd_ptr];
  assign out_quot  = quot_mem[rd_ptr];

`ifdef DIVZERO_CHECK_EN
  logic dz_in;
  logic dz_mem [DEPTH];
  logic [7:0] dz_cnt_q;

  assign dz_in   = (in_b == 8'd0);
  assign quot_st = dz_in ? 8'hFF : in_quot;
  assign out_dz  = dz_mem[rd_ptr];
  assign dz_cnt  = dz_cnt_q;

  // Divide-by-zero flag storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) dz_mem[wr_ptr] <= dz_in;
  end

  // Saturating count of accepted divide-by-zero results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 dz_cnt_q <= 8'd0;
    else if (push && dz_in && dz_cnt_q != 8'hFF) dz_cnt_q <= dz_cnt_q + 8'd1;
  end
`else
  logic unused_in_b;

  assign unused_in_b = ^in_b;
  assign quot_st     = in_quot;
  assign out_dz      = 1'b0;
  assign dz_cnt      = 8'd0;
`endif

  // Data storage is not reset; out_valid qualifies what the head shows.
  always_ff @(posedge clk) begin
    if (push) begin
      prod_mem[wr_ptr] <= in_prod;
      quot_mem[wr_ptr] <= quot_st;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
